coarse_cfo_phase_sequencer: RTL

// - Top-level controller for the coarse-CFO block. Sequences three pipelined sub-engines in fixed

---
 rtl/coarse_cfo_pkg.sv | 7 +
 rtl/coarse_cfo_phase_timer.sv | 23 ++
 rtl/coarse_cfo_phase_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/coarse_cfo_pkg.sv
// coarse_cfo_pkg: shared phase/state types and sizing constants for the coarse-CFO sequencer
package coarse_cfo_pkg;
  localparam int NUM_PHASES = 3;
  localparam int CNT_W      = 20;
  typedef enum logic [1:0] {PH_A = 2'd0, PH_EST = 2'd1, PH_D = 2'd2} phase_e;
  typedef enum logic [2:0] {IDLE, RUN_A, RUN_EST, RUN_D, DONE, ERR} seq_state_e;
endpackage

// File: rtl/coarse_cfo_phase_timer.sv
// coarse_cfo_phase_timer: saturating per-phase cycle counter with watchdog compare
module coarse_cfo_phase_timer import coarse_cfo_pkg::*; #(
  parameter int TIMEOUT = 65535
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             lat,
  output logic [CNT_W-1:0] value,
  output logic             hit
);
  logic [CNT_W-1:0] cnt;
  // value counts the current cycle too, so it is what gets latched on a done pulse
  always_comb begin
    value = &cnt ? cnt : cnt + 1'b1;
    hit   = value >= CNT_W'(TIMEOUT);
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) cnt <= '0;
    else if (clr || lat) cnt <= '0;
    else if (en) cnt <= value;
endmodule

// File: rtl/coarse_cfo_phase_sequencer.sv
// coarse_cfo_phase_sequencer: runs the A/EST/D engines in order behind an ap_* handshake, with watchdog and cycle stats
module coarse_cfo_phase_sequencer import coarse_cfo_pkg::*; #(
  parameter int TIMEOUT = 65535
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic                  ap_continue,
  output logic [NUM_PHASES-1:0] phase_start,
  input  logic [NUM_PHASES-1:0] phase_done,
  output logic                  timeout_err,
  output logic [1:0]            err_phase,
  input  logic [1:0]            stat_sel,
  output logic [CNT_W-1:0]      stat_cycles
);
  seq_state_e       state;
  phase_e           ph;
  logic             running, done_act, hit;
  logic [CNT_W-1:0] value;
  logic [CNT_W-1:0] stats [4];
  always_comb begin
    running  = state inside {RUN_A, RUN_EST, RUN_D};
    ph       = state == RUN_EST ? PH_EST : state == RUN_D ? PH_D : PH_A;
    done_act = running && phase_done[ph];
  end
  coarse_cfo_phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clr      (state == IDLE),
    .en       (running),
    .lat      (done_act),
    .value    (value),
    .hit      (hit)
  );
  // stats[3] is never written so stat_sel=3 reads back zero
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state       <= IDLE;
      ap_ready    <= 1'b0;
      ap_done     <= 1'b0;
      ap_idle     <= 1'b1;
      phase_start <= '0;
      timeout_err <= 1'b0;
      err_phase   <= '0;
      stats       <= '{default: '0};
      stat_cycles <= '0;
    end else begin
      ap_ready    <= 1'b0;
      stat_cycles <= stats[stat_sel];
      case (state)
        IDLE: if (ap_start) begin
          state       <= RUN_A;
          ap_ready    <= 1'b1;
          ap_idle     <= 1'b0;
          phase_start <= NUM_PHASES'(1);
          timeout_err <= 1'b0;
          stats       <= '{default: '0};
        end
        RUN_A, RUN_EST, RUN_D:
          if (done_act) begin
            stats[ph]   <= value;
            state       <= ph == PH_A ? RUN_EST : ph == PH_EST ? RUN_D : DONE;
            phase_start <= phase_start << 1;
            ap_done     <= ph == PH_D;
          end else if (hit) begin
            state       <= ERR;
            phase_start <= '0;
            ap_done     <= 1'b1;
            timeout_err <= 1'b1;
            err_phase   <= ph;
          end
        default: if (ap_continue) begin
          state   <= IDLE;
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
        end
      endcase
    end
endmodule
